// File: rtl/pdp1_mdu_pkg.sv
// Shared constants for the PDP-1D multiply/divide unit: op codes and FSM state encodings.
package pdp1_mdu_pkg;

  localparam logic PDP1_MDU_MUL = 1'b0;
  localparam logic PDP1_MDU_DIV = 1'b1;

  localparam logic [2:0] PDP1_MDU_IDLE = 3'd0;
  localparam logic [2:0] PDP1_MDU_PREP = 3'd1;
  localparam logic [2:0] PDP1_MDU_RUN  = 3'd2;
  localparam logic [2:0] PDP1_MDU_FIN  = 3'd3;
  localparam logic [2:0] PDP1_MDU_DONE = 3'd4;

endpackage

// File: rtl/pdp1_oc_mag.sv
// Ones-complement helper: splits a word into sign/magnitude and re-applies a sign to a
// magnitude, forcing +0 when the value is flagged zero so that -0 is never produced.
module pdp1_oc_mag #(
  parameter int W = 18
) (
  input  logic [0:W-1] i_word,
  output logic         o_sign,
  output logic [W-2:0] o_mag,
  input  logic         i_sign,
  input  logic         i_nz,
  input  logic [W-2:0] i_mag,
  output logic [0:W-1] o_word
);

  assign o_sign = i_word[0];
  assign o_mag  = i_word[1:W-1] ^ {(W-1){i_word[0]}};
  assign o_word = (i_sign && i_nz) ? ~{1'b0, i_mag} : {1'b0, i_mag};

endmodule

// File: rtl/pdp1_mdu.sv
// Iterative ones-complement multiply/divide unit for PDP-1D mul/div.
// Define PDP1_MDU_DIV_EN to build the divide datapath; otherwise every DIV reports overflow.
module pdp1_mdu
  import pdp1_mdu_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         md_start,
  input  logic         md_op,
  input  logic [0:W-1] md_a,
  input  logic [0:W-1] md_b,
  input  logic [0:W-1] md_c,
  output logic [0:W-1] md_hi,
  output logic [0:W-1] md_lo,
  output logic         md_busy,
  output logic         md_done,
  output logic         md_ovfl
);

  localparam int CW = $clog2(W);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_op;
  logic [0:W-1]  r_a, r_b, r_c, r_hi, r_lo;
  logic          r_ovfl;
  logic [W-2:0]  r_acc, r_q, r_d;
  logic          r_sq, r_sr;

  logic          w_sa, w_sc;
  logic [W-2:0]  w_ma, w_mc;
  logic [0:W-1]  w_hi_word, w_lo_word;
  logic [W-2:0]  w_hi_mag, w_lo_mag;
  logic          w_prod_nz, w_hi_nz, w_lo_nz;
  logic [W-1:0]  w_sum;

  // Operand a/c conversion shares each instance with one result word's sign fix-up.
  pdp1_oc_mag #(.W(W)) u_oc_a (
    .i_word (r_a),
    .o_sign (w_sa),
    .o_mag  (w_ma),
    .i_sign (r_sq),
    .i_nz   (w_hi_nz),
    .i_mag  (w_hi_mag),
    .o_word (w_hi_word)
  );

  pdp1_oc_mag #(.W(W)) u_oc_c (
    .i_word (r_c),
    .o_sign (w_sc),
    .o_mag  (w_mc),
    .i_sign (r_sr),
    .i_nz   (w_lo_nz),
    .i_mag  (w_lo_mag),
    .o_word (w_lo_word)
  );

  // MUL: acc holds the high half, q the multiplier shifting out / product low half in.
  assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_d} : '0);

`ifdef PDP1_MDU_DIV_EN
  logic [W-2:0] w_mb;
  logic [W-1:0] w_rs;
  logic [W-2:0] w_rdiff;
  logic         w_qbit;
  logic         w_div_ovf;

  assign w_mb      = r_b[1:W-1] ^ {(W-1){w_sa}};
  assign w_rs      = {r_acc, r_q[W-2]};
  assign w_rdiff   = w_rs[W-2:0] - r_d;
  assign w_qbit    = (w_rs >= {1'b0, r_d});
  assign w_div_ovf = (w_ma >= w_mc);
`endif

  // DIV leaves quotient in q and remainder in acc; MUL leaves high half in acc.
  assign w_prod_nz = |{r_acc, r_q};
  assign w_hi_mag  = r_op ? r_q : r_acc;
  assign w_lo_mag  = r_op ? r_acc : r_q;
  assign w_hi_nz   = r_op ? |r_q : w_prod_nz;
  assign w_lo_nz   = r_op ? |r_acc : w_prod_nz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PDP1_MDU_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_ovfl  <= 1'b0;
      r_acc   <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_sq    <= 1'b0;
      r_sr    <= 1'b0;
    end else begin
      case (r_state)
        PDP1_MDU_IDLE, PDP1_MDU_DONE: begin
          if (md_start) begin
            r_state <= PDP1_MDU_PREP;
            r_op    <= md_op;
            r_a     <= md_a;
            r_b     <= md_b;
            r_c     <= md_c;
            r_ovfl  <= 1'b0;
          end else begin
            r_state <= PDP1_MDU_IDLE;
          end
        end
        PDP1_MDU_PREP: begin
          r_sq  <= w_sa ^ w_sc;
          r_sr  <= (r_op == PDP1_MDU_DIV) ? w_sa : (w_sa ^ w_sc);
          r_cnt <= CW'(W - 2);
          if (r_op == PDP1_MDU_DIV) begin
`ifdef PDP1_MDU_DIV_EN
            if (w_div_ovf) begin
              r_ovfl  <= 1'b1;
              r_hi    <= r_a;
              r_lo    <= r_b;
              r_state <= PDP1_MDU_DONE;
            end else begin
              r_acc   <= w_ma;
              r_q     <= w_mb;
              r_d     <= w_mc;
              r_state <= PDP1_MDU_RUN;
            end
`else
            r_ovfl  <= 1'b1;
            r_hi    <= r_a;
            r_lo    <= r_b;
            r_state <= PDP1_MDU_DONE;
`endif
          end else begin
            r_acc   <= '0;
            r_q     <= w_mc;
            r_d     <= w_ma;
            r_state <= PDP1_MDU_RUN;
          end
        end
        PDP1_MDU_RUN: begin
`ifdef PDP1_MDU_DIV_EN
          if (r_op == PDP1_MDU_DIV) begin
            r_acc <= w_qbit ? w_rdiff : w_rs[W-2:0];
            r_q   <= {r_q[W-3:0], w_qbit};
          end else
`endif
          begin
            r_acc <= w_sum[W-1:1];
            r_q   <= {w_sum[0], r_q[W-2:1]};
          end
          if (r_cnt == '0) begin
            r_state <= PDP1_MDU_FIN;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        PDP1_MDU_FIN: begin
          r_hi    <= w_hi_word;
          r_lo    <= w_lo_word;
          r_state <= PDP1_MDU_DONE;
        end
        default: r_state <= PDP1_MDU_IDLE;
      endcase
    end
  end

  assign md_hi   = r_hi;
  assign md_lo   = r_lo;
  assign md_ovfl = r_ovfl;
  assign md_done = (r_state == PDP1_MDU_DONE);
  assign md_busy = (r_state == PDP1_MDU_PREP) || (r_state == PDP1_MDU_RUN) ||
                   (r_state == PDP1_MDU_FIN);

endmodule

// File: tb/tb_pdp1_mdu.sv
// Directed bench for pdp1_mdu (W=18); DIV expectations follow PDP1_MDU_DIV_EN.
module tb_pdp1_mdu;

  localparam int W = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic        md_op;
  logic [17:0] md_a, md_b, md_c;
  logic [17:0] md_hi, md_lo;
  logic        md_busy, md_done, md_ovfl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pdp1_mdu #(.W(W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .md_c     (md_c),
    .md_hi    (md_hi),
    .md_lo    (md_lo),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .md_ovfl  (md_ovfl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %o expected %o", tag, got, exp);
    end
  endtask

  // Launch one operation, optionally pulse a stray start at cycle 5, then check results.
  task automatic run_op(input string tag, input logic op, input logic [17:0] a,
                        input logic [17:0] b, input logic [17:0] c,
                        input logic [17:0] exp_hi, input logic [17:0] exp_lo,
                        input logic exp_ov, input int exp_lat, input bit glitch);
    int lat = 0;
    @(negedge clk);
    md_start = 1'b1;
    md_op    = op;
    md_a     = a;
    md_b     = b;
    md_c     = c;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    md_op    = ~op;
    md_a     = ~a;
    md_b     = ~b;
    md_c     = ~c;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (md_done) begin
        lat = n;
        break;
      end
      md_start = glitch && (n == 5);
      if (n == 2) check({tag, "/busy"}, 32'(md_busy), 32'd1);
    end
    md_start = 1'b0;
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/hi"}, 32'(md_hi), 32'(exp_hi));
    check({tag, "/lo"}, 32'(md_lo), 32'(exp_lo));
    check({tag, "/ovfl"}, 32'(md_ovfl), 32'(exp_ov));
  endtask

  task automatic div_case(input string tag, input logic [17:0] a, input logic [17:0] b,
                          input logic [17:0] c, input logic [17:0] q, input logic [17:0] r);
`ifdef PDP1_MDU_DIV_EN
    run_op(tag, 1'b1, a, b, c, q, r, 1'b0, W + 1, 1'b0);
`else
    run_op(tag, 1'b1, a, b, c, a, b, 1'b1, 1, 1'b0);
`endif
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, "/done_low"}, 32'(md_done), 32'd0);
    check({tag, "/busy_low"}, 32'(md_busy), 32'd0);
  endtask

  initial begin
    int seen_done;
    rst      = 1'b1;
    md_start = 1'b0;
    md_op    = 1'b0;
    md_a     = '0;
    md_b     = '0;
    md_c     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/hi", 32'(md_hi), 32'd0);
    check("rst/lo", 32'(md_lo), 32'd0);
    check("rst/busy", 32'(md_busy), 32'd0);
    check("rst/done", 32'(md_done), 32'd0);
    check("rst/ovfl", 32'(md_ovfl), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Multiply, back-to-back after the first
    run_op("mul3x5", 1'b0, 18'o000003, 18'o0, 18'o000005, 18'o000000, 18'o000017,
           1'b0, W + 1, 1'b0);
    run_op("mulm3x5", 1'b0, 18'o777774, 18'o0, 18'o000005, 18'o777777, 18'o777760,
           1'b0, W + 1, 1'b0);
    run_op("mul0xm5", 1'b0, 18'o000000, 18'o0, 18'o777772, 18'o000000, 18'o000000,
           1'b0, W + 1, 1'b0);
    run_op("mulmax", 1'b0, 18'o377777, 18'o0, 18'o000002, 18'o000001, 18'o377776,
           1'b0, W + 1, 1'b0);
    idle_check("after_mul");

    // Divide
    div_case("div100by7", 18'o000000, 18'o000144, 18'o000007, 18'o000016, 18'o000002);
    div_case("divm100by7", 18'o777777, 18'o377633, 18'o000007, 18'o777761, 18'o777775);
    div_case("divm14by7", 18'o777777, 18'o377761, 18'o000007, 18'o777775, 18'o000000);
    run_op("divovf", 1'b1, 18'o000007, 18'o000123, 18'o000007, 18'o000007, 18'o000123,
           1'b1, 1, 1'b0);
    run_op("divzero", 1'b1, 18'o000000, 18'o000005, 18'o000000, 18'o000000, 18'o000005,
           1'b1, 1, 1'b0);
    run_op("mul_clr_ovf", 1'b0, 18'o000003, 18'o0, 18'o000005, 18'o000000, 18'o000017,
           1'b0, W + 1, 1'b0);
    idle_check("after_div");

    // Stray start mid-operation, then a back-to-back start in the DONE cycle
    run_op("glitch", 1'b0, 18'o000003, 18'o0, 18'o000005, 18'o000000, 18'o000017,
           1'b0, W + 1, 1'b1);
    run_op("b2b", 1'b0, 18'o000005, 18'o0, 18'o000007, 18'o000000, 18'o000043,
           1'b0, W + 1, 1'b0);
    idle_check("after_b2b");

    // Reset mid-divide, with a simultaneous start that must lose to reset
    @(negedge clk);
    md_start = 1'b1;
    md_op    = 1'b1;
    md_a     = 18'o000000;
    md_b     = 18'o000144;
    md_c     = 18'o000007;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst      = 1'b1;
    md_start = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    md_start = 1'b0;
    check("midrst/hi", 32'(md_hi), 32'd0);
    check("midrst/lo", 32'(md_lo), 32'd0);
    check("midrst/busy", 32'(md_busy), 32'd0);
    check("midrst/done", 32'(md_done), 32'd0);
    check("midrst/ovfl", 32'(md_ovfl), 32'd0);
    seen_done = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (md_done || md_busy) seen_done++;
    end
    check("midrst/quiet", 32'(seen_done), 32'd0);
    run_op("postrst", 1'b0, 18'o000003, 18'o0, 18'o000005, 18'o000000, 18'o000017,
           1'b0, W + 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
